sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 114 +++++++++++
 tb/tb_sram_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Controller for a 16-bit asynchronous SRAM: each 32-bit load or store becomes two halfword
// accesses followed by WAIT_CYCLES idle cycles. ready stays low to freeze the pipeline.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

    state_t      state_q;
    op_t         op_q;
    logic [17:0] base_q;
    logic [15:0] wdata_hi_q;
    logic [3:0]  cnt_q;
    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic        we_n_q;
    logic        oe_n_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

    // Data region starts at byte 1024; each 32-bit word occupies two consecutive halfwords.
    logic [31:0] offset;
    logic [17:0] base_d;
    logic        unused_bits;
    assign offset      = address - 32'd1024;
    assign base_d      = {offset[18:2], 1'b0};
    assign unused_bits = ^{offset[31:19], offset[1:0]};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    // NOTE: the bus is released whenever the output enable flop is clear, so the SRAM can drive it.
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign read_data = read_data_q;
    assign ready     = (state_q == DONE) || ((state_q == IDLE) && !wr_en && !rd_en);

    // NOTE: every state and strobe register uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NONE;
            base_q      <= '0;
            wdata_hi_q  <= '0;
            cnt_q       <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        op_q        <= wr_en ? OP_WRITE : OP_READ;
                        base_q      <= base_d;
                        wdata_hi_q  <= write_data[31:16];
                        sram_addr_q <= base_d;
                        we_n_q      <= !wr_en;
                        oe_n_q      <= wr_en;
                        dq_oe_q     <= wr_en;
                        dq_out_q    <= write_data[15:0];
                        state_q     <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    if (op_q == OP_READ) read_data_q[15:0] <= SRAM_DQ;
                    sram_addr_q <= base_q + 18'd1;
                    dq_out_q    <= wdata_hi_q;
                    state_q     <= ACC_HI;
                end
                ACC_HI: begin
                    if (op_q == OP_READ) read_data_q[31:16] <= SRAM_DQ;
                    we_n_q  <= 1'b1;
                    oe_n_q  <= 1'b0;
                    dq_oe_q <= 1'b0;
                    cnt_q   <= 4'(WAIT_CYCLES);
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Counter is loaded with WAIT_CYCLES, so leaving at 1 gives exactly that many cycles.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= DONE;
                end
                DONE: begin
                    op_q    <= OP_NONE;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a vector table of loads/stores against a halfword SRAM model,
// write beats checked through a scoreboard, plus reset, input-freeze and back-to-back sequences.
module tb_sram_controller;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_base;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    logic        rd4;
    logic [31:0] read_data4;
    logic        ready4;
    wire  [15:0] dq4;
    logic [17:0] addr4;
    logic        we4_n, oe4_n, ce4_n, ub4_n, lb4_n;

    int    errors = 0;
    int    checks = 0;
    beat_t sb_q[$];
    vec_t  vecs[10];
    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
    );

    sram_controller #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rd4), .address(32'd1032),
        .write_data(32'd0), .read_data(read_data4), .ready(ready4), .SRAM_DQ(dq4),
        .SRAM_ADDR(addr4), .SRAM_WE_N(we4_n), .SRAM_OE_N(oe4_n),
        .SRAM_CE_N(ce4_n), .SRAM_UB_N(ub4_n), .SRAM_LB_N(lb4_n)
    );

    // Asynchronous SRAM model: drives the bus while output-enabled and not writing.
    assign sram_dq = (sram_we_n && !sram_oe_n) ? mem[sram_addr] : 16'bz;
    assign dq4     = (we4_n && !oe4_n) ? 16'h5A5A : 16'bz;

    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write beat seen on the bus must match the next expected beat.
    always @(negedge clk) begin
        beat_t b;
        if (!sram_we_n) begin
            if (sb_q.size() == 0) begin
                check("unexpected write beat", 32'(sram_addr), 32'hFFFF_FFFF);
            end else begin
                b = sb_q.pop_front();
                check("write beat addr", 32'(sram_addr), 32'(b.addr));
                check("write beat data", 32'(sram_dq), 32'(b.data));
                check("oe_n during write", 32'(sram_oe_n), 32'd1);
            end
        end
    end

    task automatic wait_ready(output int low);
        low = 0;
        while (!ready && low < 50) begin
            low++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int low;
        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        if (v.wr) begin
            sb_q.push_back('{addr: v.exp_base, data: v.wdata[15:0]});
            sb_q.push_back('{addr: v.exp_base + 18'd1, data: v.wdata[31:16]});
        end
        #1;
        wait_ready(low);
        wr_en = 1'b0; rd_en = 1'b0;
        check({tag, " latency"}, 32'(low), 32'd5);
        check({tag, " read_data"}, read_data, v.exp_rdata);
        @(negedge clk);
        #1;
        check({tag, " ready idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int low;
        vecs[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4,       32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'd4,       32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1040, 32'h12345678, 18'd8,       32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1040, 32'h0,        18'd8,       32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1027, 32'hCAFEF00D, 18'd0,       32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'd0,       32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1824, 32'hA5A55A5A, 18'd400,     32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1826, 32'h0,        18'd400,     32'hA5A55A5A};
        vecs[8] = '{1'b1, 1'b0, 32'd0,    32'h0BAD0BAD, 18'h3FE00,   32'hA5A55A5A};
        vecs[9] = '{1'b0, 1'b1, 32'd0,    32'h0,        18'h3FE00,   32'h0BAD0BAD};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd4 = 1'b0;
        address = 32'd0; write_data = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        check("reset oe_n", 32'(sram_oe_n), 32'd0);
        check("reset read_data", read_data, 32'd0);
        check("ce/ub/lb low", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);

        for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Inputs changed after the request is accepted must not affect the transaction.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1032;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'h0;
        #1;
        wait_ready(low);
        wr_en = 1'b0;
        check("frozen latency", 32'(low + 1), 32'd5);
        check("frozen read_data", read_data, 32'hDEADBEEF);

        // Reset in ACC_HI of a write abandons it.
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222;
        sb_q.push_back('{addr: 18'd12, data: 16'h2222});
        sb_q.push_back('{addr: 18'd13, data: 16'h1111});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset we_n", 32'(sram_we_n), 32'd1);
        check("mid reset ready", 32'(ready), 32'd1);
        check("mid reset read_data", read_data, 32'd0);
        do_txn(vecs[1], "post reset read");

        // Back-to-back reads on the WAIT_CYCLES=4 instance: 7 low cycles then a 1-cycle pulse.
        @(negedge clk);
        rd4 = 1'b1;
        #1;
        for (int p = 0; p < 3; p++) begin
            low = 0;
            while (!ready4 && low < 50) begin
                low++;
                @(negedge clk);
                #1;
            end
            check($sformatf("b2b low run %0d", p), 32'(low), 32'd7);
            check($sformatf("b2b read_data %0d", p), read_data4, 32'h5A5A5A5A);
            if (p == 2) rd4 = 1'b0;
            @(negedge clk);
            #1;
        end
        check("b2b idle ready", 32'(ready4), 32'd1);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
